// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store unit: size codes, FSM
// encodings and default data/address widths.
package mem_access_unit_pkg;

    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;

    typedef enum logic [1:0] {
        MAU_SZ_B = 2'b00,
        MAU_SZ_H = 2'b01,
        MAU_SZ_W = 2'b10,
        MAU_SZ_R = 2'b11
    } mau_size_e;

    typedef enum logic [1:0] {
        MAU_IDLE   = 2'd0,
        MAU_ACCESS = 2'd1,
        MAU_RESP   = 2'd2
    } mau_state_e;

endpackage

// File: rtl/mem_access_unit_ram.sv
// Private data RAM: DEPTH_WORDS x XLEN with per-lane write enables and a
// read pipeline RD_LATENCY registers deep. Array contents are not reset.
module mem_access_ram #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1,
    parameter int AW          = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN/8-1:0] we,
    input  logic [AW-1:0]     addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    localparam int LANES = XLEN / 8;

    logic [XLEN-1:0] mem  [DEPTH_WORDS];
    logic [XLEN-1:0] pipe [RD_LATENCY];

    // Byte-lane writes; lanes with a clear enable keep their old contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read pipeline: stage 0 samples the array (read-first), later stages delay it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= mem[addr];
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rdata = pipe[RD_LATENCY-1];

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit with valid/ready request and response channels.
// Optional feature macro: MAU_ALIGN_CHECK_EN. When defined, misaligned half
// and word accesses raise rsp_err; when undefined, the low address bits below
// the access size are ignored and only out-of-range or reserved-size
// accesses raise rsp_err.
//
// Handshakes: a channel transfers on a rising edge where valid and ready are
// both high; the source holds valid and its payload stable until then, and
// the response channel here keeps rsp_valid/rsp_rdata/rsp_err constant while
// rsp_ready is low.
//
// ACCESS timing: the cycle after acceptance presents the address to the RAM
// and commits any store; the next RD_LATENCY cycles wait for the read
// pipeline. Errored requests leave ACCESS on its first cycle without
// touching the RAM, so their response appears one cycle after acceptance.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN        = DATA_LEN,
    parameter int ADDR_W      = ADDR_LEN,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output mau_state_e        dbg_state
);

    localparam int LANES  = XLEN / 8;
    localparam int LANE_B = $clog2(LANES);
    localparam int IDX_W  = ADDR_W - LANE_B;
    localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W  = $clog2(RD_LATENCY + 1);

    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(RD_LATENCY);

    mau_state_e         state;
    logic [CNT_W-1:0]   cnt;

    // Request fields captured at acceptance.
    mau_size_e          lat_size;
    logic [LANE_B-1:0]  lat_off;
    logic [RAM_AW-1:0]  lat_idx;
    logic [XLEN-1:0]    lat_wdata;
    logic               lat_we;
    logic               lat_uns;
    logic               lat_err;

    // Decode of the incoming request.
    logic [LANE_B-1:0]  in_off;
    logic [LANE_B-1:0]  eff_off;
    logic [IDX_W-1:0]   in_idx;
    logic               align_err;
    logic               in_err;

    // RAM interface and datapath.
    logic [LANES-1:0]   be;
    logic [LANES-1:0]   ram_we;
    logic [XLEN-1:0]    wrep;
    logic [XLEN-1:0]    ram_rdata;
    logic [XLEN-1:0]    shifted;
    logic [XLEN-1:0]    load_data;

    assign in_off = req_addr[LANE_B-1:0];
    assign in_idx = req_addr[ADDR_W-1:LANE_B];

`ifdef MAU_ALIGN_CHECK_EN
    assign align_err = ((mau_size_e'(req_size) == MAU_SZ_H) && in_off[0]) ||
                       ((mau_size_e'(req_size) == MAU_SZ_W) && (|in_off));
`else
    assign align_err = 1'b0;
`endif

    // Force the lane offset onto the natural boundary of the access size.
    always_comb begin
        eff_off = in_off;
        case (mau_size_e'(req_size))
            MAU_SZ_H: eff_off[0] = 1'b0;
            MAU_SZ_W: eff_off    = '0;
            default:  ;
        endcase
    end

    assign in_err = (mau_size_e'(req_size) == MAU_SZ_R) || align_err ||
                    (in_idx >= DEPTH_IDX);

    // Byte enables and lane-replicated store data for the captured request.
    always_comb begin
        be   = '0;
        wrep = lat_wdata;
        case (lat_size)
            MAU_SZ_B: begin
                be   = LANES'(1) << lat_off;
                wrep = {LANES{lat_wdata[7:0]}};
            end
            MAU_SZ_H: begin
                be   = LANES'(3) << lat_off;
                wrep = {(LANES/2){lat_wdata[15:0]}};
            end
            MAU_SZ_W: be = '1;
            default:  be = '0;
        endcase
    end

    // Store commits only on the first ACCESS edge; reset on that edge cancels it.
    assign ram_we = ((state == MAU_ACCESS) && (cnt == '0) && lat_we && !lat_err && !rst)
                    ? be : '0;

    mem_access_ram #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS),
        .RD_LATENCY  (RD_LATENCY),
        .AW          (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .addr  (lat_idx),
        .wdata (wrep),
        .rdata (ram_rdata)
    );

    // Align the addressed bytes to bit 0, then truncate and extend to XLEN.
    always_comb begin
        shifted = ram_rdata >> {lat_off, 3'b000};
        case (lat_size)
            MAU_SZ_B: load_data = lat_uns ? XLEN'(shifted[7:0])
                                          : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MAU_SZ_H: load_data = lat_uns ? XLEN'(shifted[15:0])
                                          : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            default:  load_data = shifted;
        endcase
    end

    // Control FSM with registered channel outputs and request capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MAU_IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_size  <= MAU_SZ_B;
            lat_off   <= '0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_err   <= 1'b0;
        end else begin
            case (state)
                MAU_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        lat_size  <= mau_size_e'(req_size);
                        lat_off   <= eff_off;
                        lat_idx   <= in_idx[RAM_AW-1:0];
                        lat_wdata <= req_wdata;
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_err   <= in_err;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        state     <= MAU_ACCESS;
                    end
                end
                MAU_ACCESS: begin
                    if (lat_err) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= MAU_RESP;
                    end else if (cnt == LAST_CNT) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= lat_we ? '0 : load_data;
                        state     <= MAU_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MAU_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= MAU_IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b0;
                    state     <= MAU_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. Honours MAU_ALIGN_CHECK_EN the
// same way the design does. Expected responses come from a byte-level memory
// model or from literal values, and are queued when each request is driven.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [XLEN-1:0]   req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    mau_state_e        dbg_state;

    int checks = 0;
    int errors = 0;

    logic [XLEN:0]   exp_q[$];
    logic [XLEN-1:0] mdl [DEPTH];

    mem_access_unit #(
        .XLEN        (XLEN),
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH),
        .RD_LATENCY  (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: returns {err, rdata} and applies stores to mdl.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [XLEN:0] res);
        int unsigned idx;
        int unsigned off;
        logic err;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        idx = addr >> 2;
        off = addr % 4;
        err = (sz == 2'b11);
`ifdef MAU_ALIGN_CHECK_EN
        if (sz == 2'b01 && (off % 2) != 0) err = 1'b1;
        if (sz == 2'b10 && off != 0) err = 1'b1;
`else
        if (sz == 2'b01) off = off - (off % 2);
        if (sz == 2'b10) off = 0;
`endif
        if (idx >= DEPTH) err = 1'b1;
        res = '0;
        if (err) begin
            res = {1'b1, 32'h0};
        end else if (we) begin
            case (sz)
                2'b00: mdl[idx][8*off +: 8]  = wd[7:0];
                2'b01: mdl[idx][8*off +: 16] = wd[15:0];
                default: mdl[idx] = wd;
            endcase
        end else begin
            w = mdl[idx];
            case (sz)
                2'b00: begin
                    b = w[8*off +: 8];
                    res[31:0] = uns ? {24'h0, b} : {{24{b[7]}}, b};
                end
                2'b01: begin
                    h = w[8*off +: 16];
                    res[31:0] = uns ? {16'h0, h} : {{16{h[15]}}, h};
                end
                default: res[31:0] = w;
            endcase
        end
    endtask

    // Waits (bounded) until req_ready, sampled #1 after an edge.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
    endtask

    // Drives one request, pushes its expectation, collects and checks the response.
    // use_exp selects literal expectations; hold>0 stalls rsp_ready for that many cycles.
    task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input bit use_exp, input logic exp_err, input logic [31:0] exp_data,
                          input int hold);
        logic [XLEN:0] m;
        logic [XLEN:0] e;
        logic [XLEN:0] snap;
        int lat;
        model(we, sz, uns, addr, wd, m);
        if (use_exp) m = {exp_err, exp_data};
        exp_q.push_back(m);
        wait_ready();
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        rsp_ready    = (hold == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({tag, "_ready_low"}, 64'(req_ready), 64'd0);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = exp_q.pop_front();
        check({tag, "_latency"}, 64'(lat), e[XLEN] ? 64'd1 : 64'(1 + RD_LAT));
        check(tag, 64'({rsp_err, rsp_rdata}), 64'(e));
        if (hold > 0) begin
            snap = {rsp_err, rsp_rdata};
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
                check({tag, "_hold_data"}, 64'({rsp_err, rsp_rdata}), 64'(snap));
                check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_consumed"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        logic [XLEN:0] dummy;
        logic [31:0] old_w;
        logic [1:0] sz;
        logic [31:0] addr;
        logic we;

        // Reset block
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Fill words 0..15 so every later load reads known data.
        for (int i = 0; i < 16; i++) begin
            do_req("init_sw", 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 1'b0, 1'b0, 32'h0, 0);
        end

        // Directed cases with literal expectations.
        do_req("sw_dead", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 0);
        do_req("lw_dead", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 0);
        do_req("sb_7f", 1'b1, 2'b00, 1'b0, 32'h11, 32'h1234567F, 1'b1, 1'b0, 32'h0, 0);
        do_req("lw_merge", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEAD7FEF, 0);
        do_req("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 32'hFFFFFFDE, 0);
        do_req("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 32'h000000DE, 0);
        do_req("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'hFFFFDEAD, 0);
        do_req("lhu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000DEAD, 0);
`ifdef MAU_ALIGN_CHECK_EN
        do_req("lh_mis_11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1, 1'b1, 32'h0, 0);
        do_req("lw_mis_12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 32'h0, 0);
`else
        do_req("lh_force_13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 32'hFFFFDEAD, 0);
        do_req("lw_force_12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'hDEAD7FEF, 0);
`endif
        do_req("sw_oor", 1'b1, 2'b10, 1'b0, 32'(DEPTH * 4), 32'hBAD0BAD0, 1'b1, 1'b1, 32'h0, 0);
        do_req("lw_0_intact", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        do_req("lw_oor", 1'b0, 2'b10, 1'b0, 32'(DEPTH * 4 + 8), 32'h0, 1'b1, 1'b1, 32'h0, 0);
        do_req("size_rsv", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0, 0);
        do_req("lw_stall", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEAD7FEF, 5);
        do_req("err_stall", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 3);

        // Reset on the commit edge of a store: the write must not happen.
        old_w = mdl[8];
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h20;
        req_wdata = ~old_w;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("after_rst_req_ready", 64'(req_ready), 64'd1);
        do_req("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, old_w, 0);

        // Random mixed traffic over the initialised words.
        for (int i = 0; i < 60; i++) begin
            sz   = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 63));
            we   = 1'($urandom_range(0, 1));
            do_req("rand", we, sz, 1'($urandom_range(0, 1)), addr, $urandom, 1'b0, 1'b0, 32'h0, 0);
        end

        // Final read-back of every word against the model.
        for (int i = 0; i < 16; i++) begin
            do_req("readback", 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0, 0);
        end

        model(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, dummy);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
